// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave with a 128 x 32-bit register file in a 512-byte window.
// Write (AW/W/B) and read (AR/R) channels run independently; out-of-window accesses return SLVERR.
`timescale 1ns/1ps
module axi4_lite_slave_regs #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned REG_ADDR_BITS = 9
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  awvalid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  bready,
  input  logic                  arvalid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  rready,
  output logic                  awready,
  output logic                  wready,
  output logic                  bvalid,
  output logic [1:0]            bresp,
  output logic                  arready,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned IDX_W    = REG_ADDR_BITS - 2;
  localparam int unsigned NUM_REGS = 1 << IDX_W;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] latched_addr_w, latched_addr_w_d;
  logic [DATA_WIDTH-1:0] latched_data_w_q, latched_data_w_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  reg_we_c;

  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] latched_addr_r_q, latched_addr_r_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  w_in_range_c, r_in_range_c;
  logic [IDX_W-1:0]      w_idx_c, r_idx_c;
  logic [3:0]            unused_addr_bits;

  // Byte-lane bits are ignored; only the upper address bits gate the window.
  assign w_in_range_c     = (latched_addr_w[ADDR_WIDTH-1:REG_ADDR_BITS] == '0);
  assign r_in_range_c     = (latched_addr_r_q[ADDR_WIDTH-1:REG_ADDR_BITS] == '0);
  assign w_idx_c          = latched_addr_w[REG_ADDR_BITS-1:2];
  assign r_idx_c          = latched_addr_r_q[REG_ADDR_BITS-1:2];
  assign unused_addr_bits = {latched_addr_w[1:0], latched_addr_r_q[1:0]};

  // Write channel: AW and W captured independently, committed once both are held.
  always_comb begin
    w_state_d        = w_state_q;
    aw_held_d        = aw_held_q;
    w_held_d         = w_held_q;
    latched_addr_w_d = latched_addr_w;
    latched_data_w_d = latched_data_w_q;
    awready_d        = awready_q;
    wready_d         = wready_q;
    bvalid_d         = bvalid_q;
    bresp_d          = bresp_q;
    reg_we_c         = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready_q) begin
          latched_addr_w_d = awaddr;
          aw_held_d        = 1'b1;
        end
        if (wvalid && wready_q) begin
          latched_data_w_d = wdata;
          w_held_d         = 1'b1;
        end
        if (aw_held_q && w_held_q) begin
          reg_we_c  = w_in_range_c;
          bresp_d   = w_in_range_c ? RESP_OKAY : RESP_SLVERR;
          bvalid_d  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          awready_d = !aw_held_d;
          wready_d  = !w_held_d;
        end
      end
      W_RESP: begin
        if (bvalid_q && bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
    endcase
  end

  // Read channel: capture address, present data the following edge, hold until rready.
  always_comb begin
    r_state_d        = r_state_q;
    latched_addr_r_d = latched_addr_r_q;
    arready_d        = arready_q;
    rvalid_d         = rvalid_q;
    rresp_d          = rresp_q;
    rdata_d          = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          latched_addr_r_d = araddr;
          arready_d        = 1'b0;
          r_state_d        = R_DATA;
        end
      end
      R_DATA: begin
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
          rdata_d  = r_in_range_c ? regs_q[r_idx_c] : '0;
          rresp_d  = r_in_range_c ? RESP_OKAY : RESP_SLVERR;
        end else if (rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q        <= W_IDLE;
      aw_held_q        <= 1'b0;
      w_held_q         <= 1'b0;
      latched_addr_w   <= '0;
      latched_data_w_q <= '0;
      awready_q        <= 1'b0;
      wready_q         <= 1'b0;
      bvalid_q         <= 1'b0;
      bresp_q          <= 2'b00;
      r_state_q        <= R_IDLE;
      latched_addr_r_q <= '0;
      arready_q        <= 1'b0;
      rvalid_q         <= 1'b0;
      rresp_q          <= 2'b00;
      rdata_q          <= '0;
    end else begin
      w_state_q        <= w_state_d;
      aw_held_q        <= aw_held_d;
      w_held_q         <= w_held_d;
      latched_addr_w   <= latched_addr_w_d;
      latched_data_w_q <= latched_data_w_d;
      awready_q        <= awready_d;
      wready_q         <= wready_d;
      bvalid_q         <= bvalid_d;
      bresp_q          <= bresp_d;
      r_state_q        <= r_state_d;
      latched_addr_r_q <= latched_addr_r_d;
      arready_q        <= arready_d;
      rvalid_q         <= rvalid_d;
      rresp_q          <= rresp_d;
      rdata_q          <= rdata_d;
    end
  end

  // Register file; a concurrent read samples regs_q, so it sees the pre-write value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we_c) begin
      regs_q[w_idx_c] <= latched_data_w_q;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Scoreboard bench for axi4_lite_slave_regs: expected responses queued at issue, compared at handshake.
`timescale 1ns/1ps
module tb_axi4_lite_slave_regs;

  logic        aclk;
  logic        aresetn;
  logic        awvalid;
  logic [31:0] awaddr;
  logic        wvalid;
  logic [31:0] wdata;
  logic        bready;
  logic        arvalid;
  logic [31:0] araddr;
  logic        rready;
  logic        awready;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        arready;
  logic [1:0]  rresp;
  logic        rvalid;
  logic [31:0] rdata;

  axi4_lite_slave_regs dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .awvalid (awvalid),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wdata   (wdata),
    .bready  (bready),
    .arvalid (arvalid),
    .araddr  (araddr),
    .rready  (rready),
    .awready (awready),
    .wready  (wready),
    .bvalid  (bvalid),
    .bresp   (bresp),
    .arready (arready),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rdata   (rdata)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          b_seen   = 0;
  int          r_seen   = 0;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  logic [31:0] model [128];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return a[31:9] == 23'd0;
  endfunction

  // Response monitor: sampled on the falling edge, pops the scoreboard at each handshake.
  always @(negedge aclk) begin
    if (aresetn && bvalid && bready) begin
      if (bq.size() == 0) check("b_unexpected", 32'd1, 32'd0);
      else check("bresp", 32'(bresp), 32'(bq.pop_front()));
      b_seen++;
    end
    if (aresetn && rvalid && rready) begin
      if (rq.size() == 0) check("r_unexpected", 32'd1, 32'd0);
      else begin
        logic [33:0] e;
        e = rq.pop_front();
        check("rdata", rdata, e[31:0]);
        check("rresp", 32'(rresp), 32'(e[33:32]));
      end
      r_seen++;
    end
  end

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input int lead);
    bq.push_back(in_rng(a) ? 2'b00 : 2'b10);
    if (in_rng(a)) model[a[8:2]] = d;
    @(posedge aclk); #1;
    if (lead == 0) begin
      awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d;
      @(negedge aclk);
      check("aw_ready_idle", 32'(awready), 32'd1);
      check("w_ready_idle", 32'(wready), 32'd1);
    end else begin
      wvalid = 1'b1; wdata = d;
      @(posedge aclk); #1;
      wvalid = 1'b0;
      repeat (lead - 1) @(posedge aclk);
      #1;
      awvalid = 1'b1; awaddr = a;
      @(negedge aclk);
      check("w_ready_held", 32'(wready), 32'd0);
      check("aw_ready_wait", 32'(awready), 32'd1);
    end
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    check("bvalid_early", 32'(bvalid), 32'd0);
    check("aw_ready_busy", 32'(awready), 32'd0);
    @(negedge aclk);
    check("bvalid_latency", 32'(bvalid), 32'd1);
  endtask

  task automatic drive_read(input logic [31:0] a);
    rq.push_back({in_rng(a) ? 2'b00 : 2'b10, in_rng(a) ? model[a[8:2]] : 32'd0});
    @(posedge aclk); #1;
    arvalid = 1'b1; araddr = a;
    @(negedge aclk);
    check("ar_ready_idle", 32'(arready), 32'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    @(negedge aclk);
    check("rvalid_early", 32'(rvalid), 32'd0);
    check("ar_ready_busy", 32'(arready), 32'd0);
    @(negedge aclk);
    check("rvalid_latency", 32'(rvalid), 32'd1);
  endtask

  task automatic wait_b(input int start);
    for (int i = 0; i < 20 && b_seen == start; i++) @(posedge aclk);
    if (b_seen == start) check("b_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_r(input int start);
    for (int i = 0; i < 20 && r_seen == start; i++) @(posedge aclk);
    if (r_seen == start) check("r_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lead);
    int s;
    s = b_seen;
    drive_write(a, d, lead);
    wait_b(s);
  endtask

  task automatic do_read(input logic [31:0] a);
    int s;
    s = r_seen;
    drive_read(a);
    wait_r(s);
  endtask

  initial begin
    int s;
    logic [31:0] held;
    for (int i = 0; i < 128; i++) model[i] = 32'd0;
    aresetn = 1'b0; awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0;
    bready = 1'b1; arvalid = 1'b0; araddr = '0; rready = 1'b1;

    repeat (5) @(posedge aclk);
    @(negedge aclk);
    check("rst_outputs", {awready, wready, bvalid, bresp, arready, rresp, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check("ready_after_rst", {awready, wready, arready}, 32'h7);

    do_read(32'h000);

    do_write(32'h004, 32'hDEADBEEF, 0);
    repeat (5) @(negedge aclk);
    check("bresp_hold", 32'(bresp), 32'd0);
    check("bvalid_dropped", 32'(bvalid), 32'd0);

    do_read(32'h004);
    repeat (3) @(negedge aclk);
    check("rdata_hold", rdata, 32'hDEADBEEF);
    check("rresp_hold", 32'(rresp), 32'd0);

    do_write(32'h2000, 32'hAAAA5555, 0);
    @(negedge aclk);
    check("latched_addr_w", dut.latched_addr_w, 32'h00002000);
    check("latched_addr_w_hi", 32'(dut.latched_addr_w[31:9]), 32'h10);
    check("bresp_slverr_hold", 32'(bresp), 32'd2);
    do_read(32'h000);
    do_read(32'h2000);

    // Write and read response backpressure.
    bready = 1'b0;
    s = b_seen;
    drive_write(32'h008, 32'h0BADF00D, 0);
    repeat (3) begin
      @(negedge aclk);
      check("bp_bvalid", 32'(bvalid), 32'd1);
      check("bp_bresp", 32'(bresp), 32'd0);
      check("bp_readies", {awready, wready}, 32'd0);
    end
    @(posedge aclk); #1;
    bready = 1'b1;
    wait_b(s);

    rready = 1'b0;
    s = r_seen;
    drive_read(32'h008);
    held = rdata;
    check("bp_rdata_first", held, 32'h0BADF00D);
    repeat (3) begin
      @(negedge aclk);
      check("bp_rvalid", 32'(rvalid), 32'd1);
      check("bp_rdata", rdata, held);
      check("bp_arready", 32'(arready), 32'd0);
    end
    @(posedge aclk); #1;
    rready = 1'b1;
    wait_r(s);

    // Data ahead of address by two cycles.
    do_write(32'h1FC, 32'h12345678, 2);
    do_read(32'h1FC);
    do_read(32'h004);

    // Reset while a write response is pending.
    bready = 1'b0;
    drive_write(32'h010, 32'hCAFEF00D, 0);
    #1;
    aresetn = 1'b0;
    #1;
    check("rst_mid_bvalid", 32'(bvalid), 32'd0);
    check("rst_mid_readies", {awready, wready, arready}, 32'd0);
    bq.delete();
    for (int i = 0; i < 128; i++) model[i] = 32'd0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    bready = 1'b1;
    do_read(32'h010);
    do_read(32'h1FC);

    repeat (3) @(posedge aclk);
    check("bq_empty", 32'(bq.size()), 32'd0);
    check("rq_empty", 32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
